// File: rtl/result_ascii_tx_if.sv
// result_ascii_tx_if: command/result and UART byte handshake bundle for result_ascii_tx.
// Ports: start, alu_in (command side); tx_done (UART side) in;
//        d_out, tx_start, busy, done out of the converter.
interface result_ascii_tx_if;
    logic        start;
    logic [31:0] alu_in;
    logic        tx_done;
    logic [7:0]  d_out;
    logic        tx_start;
    logic        busy;
    logic        done;

    // Driver side: interface FSM plus UART transmitter.
    modport master (
        output start, alu_in, tx_done,
        input  d_out, tx_start, busy, done
    );

    // Converter side.
    modport slave (
        input  start, alu_in, tx_done,
        output d_out, tx_start, busy, done
    );
endinterface

// File: rtl/result_ascii_tx.sv
// result_ascii_tx: converts a 32-bit ALU result to decimal ASCII and feeds the UART TX bytewise.
// Latency: start edge -> 1 LOAD cycle + one cycle per subtraction/digit (~100 worst) -> first tx_start.
// Backpressure: each byte waits for a tx_done rising edge; start edges while busy are dropped.
// Ports: clk, reset (async active-low), bus.slave = {start, alu_in, tx_done} in,
//        {d_out, tx_start, busy, done} out.
module result_ascii_tx #(
    parameter bit         SIGNED     = 1'b1,
    parameter logic [7:0] DELIM      = 8'h20,
    parameter bit         SEND_DELIM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    result_ascii_tx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CONVERT, S_SEND, S_WAIT, S_FINISH
    } state_t;

    state_t      state, state_nxt;
    logic        start_q, tx_done_q;
    logic        start_edge, tx_done_edge;
    logic [31:0] value_q;
    logic [31:0] mag;
    logic [31:0] pow;
    logic [3:0]  k;
    logic [3:0]  digit;
    logic [3:0]  cnt;
    logic [3:0]  rd, rd_nxt;
    logic        started;
    logic        neg, ge, leading;
    logic        push_digit, push_delim;
    logic [7:0]  digit_chr, send_byte;
    logic [7:0]  byte_buf [12];
    logic [7:0]  d_out_q;
    logic        tx_start_q, busy_q, done_q;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    assign start_edge   = bus.start & ~start_q;
    assign tx_done_edge = bus.tx_done & ~tx_done_q;
    assign neg          = SIGNED && value_q[31];
    assign pow          = pow10(k);
    assign ge           = (mag >= pow);
    assign digit_chr    = 8'h30 + {4'd0, digit};
    // A zero is suppressed only before any nonzero digit, and never in the units place.
    assign leading      = (digit == 4'd0) && !started && (k != 4'd0);
    assign push_digit   = (state == S_CONVERT) && !ge && !leading;
    assign push_delim   = SEND_DELIM && (state == S_CONVERT) && !ge && (k == 4'd0);

    // When the conversion finishes with an empty buffer (non-negative single digit),
    // the digit is being written on this same edge, so bypass it straight to d_out.
    assign send_byte = (state == S_CONVERT && cnt == 4'd0) ? digit_chr : byte_buf[rd_nxt];

    always_comb begin
        state_nxt = state;
        rd_nxt    = rd;
        case (state)
            S_IDLE:    if (start_edge) state_nxt = S_LOAD;
            S_LOAD: begin
                state_nxt = S_CONVERT;
                rd_nxt    = 4'd0;
            end
            S_CONVERT: if (!ge && k == 4'd0) state_nxt = S_SEND;
            S_SEND:    state_nxt = S_WAIT;
            S_WAIT: begin
                if (tx_done_edge) begin
                    rd_nxt    = rd + 4'd1;
                    state_nxt = (rd_nxt == cnt) ? S_FINISH : S_SEND;
                end
            end
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            start_q    <= 1'b1;   // a start level already high at release is not an edge
            tx_done_q  <= 1'b0;
            value_q    <= '0;
            mag        <= '0;
            k          <= '0;
            digit      <= '0;
            cnt        <= '0;
            rd         <= '0;
            started    <= 1'b0;
            d_out_q    <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= bus.start;
            tx_done_q <= bus.tx_done;
            rd        <= rd_nxt;
            // Outputs are registered from the next state so they line up with the state cycle.
            tx_start_q <= (state_nxt == S_SEND);
            busy_q     <= (state_nxt == S_LOAD) || (state_nxt == S_CONVERT) ||
                          (state_nxt == S_SEND) || (state_nxt == S_WAIT);
            done_q     <= (state_nxt == S_FINISH);
            if (state_nxt == S_SEND) d_out_q <= send_byte;
            case (state)
                S_IDLE: if (start_edge) value_q <= bus.alu_in;
                S_LOAD: begin
                    // 0x80000000 negates to itself, which read unsigned is 2147483648.
                    mag     <= neg ? (~value_q + 32'd1) : value_q;
                    k       <= 4'd9;
                    digit   <= 4'd0;
                    started <= 1'b0;
                    cnt     <= neg ? 4'd1 : 4'd0;
                end
                S_CONVERT: begin
                    if (ge) begin
                        mag   <= mag - pow;
                        digit <= digit + 4'd1;
                    end else begin
                        digit <= 4'd0;
                        k     <= k - 4'd1;
                        cnt   <= cnt + {3'd0, push_digit} + {3'd0, push_delim};
                        if (push_digit) started <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD && neg) byte_buf[0] <= 8'h2D;
        if (push_digit) byte_buf[cnt] <= digit_chr;
        if (push_delim) byte_buf[cnt + 4'd1] <= DELIM;
    end

    assign bus.d_out    = d_out_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Bench for result_ascii_tx: three instances (default, unsigned, no delimiter) share clk/reset.
// Stimulus pushes expected bytes and a done marker into one scoreboard queue; a monitor
// pops and compares on every tx_start and done.
module tb_result_ascii_tx;

    logic clk;
    logic reset;

    logic        start_v  [3];
    logic [31:0] alu_v    [3];
    logic        txd_v    [3];
    logic [7:0]  dout_w   [3];
    logic        txs_w    [3];
    logic        busy_w   [3];
    logic        done_w   [3];
    bit          auto_rsp [3];
    int          rsp_cnt  [3];
    int          tsc      [3];
    logic        txd_prev [3];
    logic        txs_prev [3];
    logic        done_prev[3];

    int n_chk;
    int n_fail;

    typedef struct {
        int         dut;
        bit         is_done;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    result_ascii_tx_if b0 ();
    result_ascii_tx_if b1 ();
    result_ascii_tx_if b2 ();

    result_ascii_tx #(.SIGNED(1'b1), .DELIM(8'h20), .SEND_DELIM(1'b1))
        u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    result_ascii_tx #(.SIGNED(1'b0), .DELIM(8'h20), .SEND_DELIM(1'b1))
        u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    result_ascii_tx #(.SIGNED(1'b1), .DELIM(8'h20), .SEND_DELIM(1'b0))
        u_dut2 (.clk(clk), .reset(reset), .bus(b2));

    assign b0.start = start_v[0];  assign b0.alu_in = alu_v[0];  assign b0.tx_done = txd_v[0];
    assign b1.start = start_v[1];  assign b1.alu_in = alu_v[1];  assign b1.tx_done = txd_v[1];
    assign b2.start = start_v[2];  assign b2.alu_in = alu_v[2];  assign b2.tx_done = txd_v[2];
    assign dout_w[0] = b0.d_out;  assign txs_w[0] = b0.tx_start;  assign busy_w[0] = b0.busy;  assign done_w[0] = b0.done;
    assign dout_w[1] = b1.d_out;  assign txs_w[1] = b1.tx_start;  assign busy_w[1] = b1.busy;  assign done_w[1] = b1.done;
    assign dout_w[2] = b2.d_out;  assign txs_w[2] = b2.tx_start;  assign busy_w[2] = b2.busy;  assign done_w[2] = b2.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic push_exp(input int i, input string s);
        exp_t e;
        for (int j = 0; j < s.len(); j++) begin
            e.dut = i; e.is_done = 1'b0; e.b = s[j];
            exp_q.push_back(e);
        end
        e.dut = i; e.is_done = 1'b1; e.b = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic wait_tsc(input int i, input int target, input int budget, input string name);
        int c;
        c = 0;
        while (tsc[i] < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (tsc[i] < target) fail(name);
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        int c;
        c = 0;
        while (!done_w[i] && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!done_w[i]) fail(name);
    endtask

    // One full transmission with the auto responder; start is held high across done.
    // With glitch set, start drops and rises again while the first byte is in WAIT.
    task automatic send(input int i, input logic [31:0] v, input string s, input bit glitch);
        int  base;
        int  c;
        bit  dropped;
        bit  toggled;
        base = tsc[i]; c = 0; dropped = 1'b0; toggled = 1'b0;
        push_exp(i, s);
        alu_v[i] = v;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        while (!done_w[i] && c < 3000) begin
            if (!busy_w[i]) dropped = 1'b1;
            if (glitch && !toggled && tsc[i] == base + 1) begin
                start_v[i] = 1'b0;
                @(negedge clk);
                start_v[i] = 1'b1;
                toggled = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        if (!done_w[i]) fail($sformatf("dut%0d_done_wait", i));
        chk($sformatf("dut%0d_busy_throughout", i), {31'd0, dropped}, 32'd0);
        chk($sformatf("dut%0d_tx_start_count", i), tsc[i] - base, s.len());
        chk($sformatf("dut%0d_dout_hold_last", i), {24'd0, dout_w[i]}, {24'd0, s[s.len()-1]});
        repeat (6) @(negedge clk);
        chk($sformatf("dut%0d_no_retrigger_busy", i), {31'd0, busy_w[i]}, 32'd0);
        chk($sformatf("dut%0d_no_extra_tx_start", i), tsc[i] - base, s.len());
        chk($sformatf("dut%0d_scoreboard_drained", i), exp_q.size(), 0);
        start_v[i] = 1'b0;
        @(negedge clk);
    endtask

    // UART model: tx_done pulses for one cycle, 20 cycles after each tx_start.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    rsp_cnt[i] = 0;
                end else if (auto_rsp[i]) begin
                    txd_v[i] = 1'b0;
                    if (rsp_cnt[i] != 0) begin
                        rsp_cnt[i]--;
                        if (rsp_cnt[i] == 0) txd_v[i] = 1'b1;
                    end
                    if (txs_w[i]) rsp_cnt[i] = 20;
                end
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        for (int i = 0; i < 3; i++) begin
            tsc[i] = 0; txd_prev[i] = 1'b0; txs_prev[i] = 1'b0; done_prev[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (txs_w[i]) begin
                    tsc[i]++;
                    chk($sformatf("dut%0d_busy_at_tx_start", i), {31'd0, busy_w[i]}, 32'd1);
                    chk($sformatf("dut%0d_tx_start_single_cycle", i), {31'd0, txs_prev[i]}, 32'd0);
                    if (exp_q.size() == 0) begin
                        fail($sformatf("dut%0d_unexpected_tx_start", i));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("dut%0d_byte_source", i), mon_e.dut, i);
                        chk($sformatf("dut%0d_byte_not_done", i), {31'd0, mon_e.is_done}, 32'd0);
                        chk($sformatf("dut%0d_byte", i), {24'd0, dout_w[i]}, {24'd0, mon_e.b});
                    end
                end
                if (done_w[i]) begin
                    chk($sformatf("dut%0d_busy_low_at_done", i), {31'd0, busy_w[i]}, 32'd0);
                    chk($sformatf("dut%0d_done_single_cycle", i), {31'd0, done_prev[i]}, 32'd0);
                    // done registers on the same edge that first samples the final tx_done rise.
                    chk($sformatf("dut%0d_done_after_tx_done", i),
                        {31'd0, (txd_v[i] && !txd_prev[i])}, 32'd1);
                    if (exp_q.size() == 0) begin
                        fail($sformatf("dut%0d_unexpected_done", i));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("dut%0d_done_source", i), mon_e.dut, i);
                        chk($sformatf("dut%0d_done_expected", i), {31'd0, mon_e.is_done}, 32'd1);
                    end
                end
                txd_prev[i]  = txd_v[i];
                txs_prev[i]  = txs_w[i];
                done_prev[i] = done_w[i];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; alu_v[i] = 32'd0; txd_v[i] = 1'b0; auto_rsp[i] = 1'b1; rsp_cnt[i] = 0;
        end
        start_v[1] = 1'b1;   // already high when reset releases: must not fire
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_reset_d_out", i),    {24'd0, dout_w[i]}, 32'd0);
            chk($sformatf("dut%0d_reset_tx_start", i), {31'd0, txs_w[i]},  32'd0);
            chk($sformatf("dut%0d_reset_busy", i),     {31'd0, busy_w[i]}, 32'd0);
            chk($sformatf("dut%0d_reset_done", i),     {31'd0, done_w[i]}, 32'd0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("dut1_start_high_at_release_busy", {31'd0, busy_w[1]}, 32'd0);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);

        send(0, 32'd1234,       "1234 ",        1'b0);
        send(0, 32'd0,          "0 ",           1'b0);
        send(2, 32'd0,          "0",            1'b0);
        send(0, 32'hFFFF_FFFB,  "-5 ",          1'b0);
        send(1, 32'hFFFF_FFFB,  "4294967291 ",  1'b0);
        send(0, 32'h8000_0000,  "-2147483648 ", 1'b0);
        send(0, 32'd7,          "7 ",           1'b1);

        // tx_done already high when WAIT is entered must not advance the read pointer.
        auto_rsp[2] = 1'b0;
        txd_v[2] = 1'b1;
        base = tsc[2];
        push_exp(2, "42");
        alu_v[2] = 32'd42;
        @(negedge clk);
        start_v[2] = 1'b1;
        wait_tsc(2, base + 1, 500, "dut2_first_byte_wait");
        repeat (10) @(negedge clk);
        chk("dut2_tx_done_held_no_advance", tsc[2] - base, 1);
        txd_v[2] = 1'b0;
        @(negedge clk);
        txd_v[2] = 1'b1;
        wait_tsc(2, base + 2, 50, "dut2_second_byte_wait");
        chk("dut2_second_byte_after_toggle", tsc[2] - base, 2);
        @(negedge clk);
        txd_v[2] = 1'b0;
        @(negedge clk);
        txd_v[2] = 1'b1;
        wait_done(2, 50, "dut2_done_wait");
        chk("dut2_manual_scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        txd_v[2] = 1'b0;
        start_v[2] = 1'b0;
        auto_rsp[2] = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during the third WAIT aborts at once.
        base = tsc[0];
        push_exp(0, "1234 ");
        alu_v[0] = 32'd1234;
        @(negedge clk);
        start_v[0] = 1'b1;
        wait_tsc(0, base + 3, 1000, "dut0_third_byte_wait");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        start_v[0] = 1'b0;
        #1;
        chk("dut0_abort_d_out",    {24'd0, dout_w[0]}, 32'd0);
        chk("dut0_abort_tx_start", {31'd0, txs_w[0]},  32'd0);
        chk("dut0_abort_busy",     {31'd0, busy_w[0]}, 32'd0);
        chk("dut0_abort_done",     {31'd0, done_w[0]}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 32'd1234, "1234 ", 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/result_ascii_tx.md
Name: result_ascii_tx

Overview:
- Downstream stage of the UART/ALU command interface: takes the 32-bit ALU result and converts it to decimal ASCII text.
- Feeds the UART transmitter one byte at a time through a tx_start/tx_done handshake.
- Conversion order: optional '-', then digits from most significant down, no leading zeros, then an optional delimiter byte.
- Launched by the interface FSM's start_conversion level.

Parameters:
- SIGNED, 1: 1 treats alu_in as two's complement; 0 treats it as unsigned.
- DELIM, 8'h20: terminator byte; space, the same delimiter the receive path uses.
- SEND_DELIM, 1: 1 appends DELIM after the last digit; 0 omits it.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level from the interface FSM; the 0->1 edge launches one transmission.
- alu_in  in  32  ALU result; sampled on the accepted start edge.
- tx_done  in  1  UART TX byte-complete; the 0->1 edge is the event.
- d_out  out  8  byte to UART TX; stable from tx_start until the next byte is loaded.
- tx_start  out  1  one-cycle pulse requesting transmission of d_out.
- busy  out  1  high from the accepted start edge until done.
- done  out  1  one-cycle pulse after the final byte's tx_done edge.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Edge-detect registers clear. start_q resets to 1, so a start level that is already high at reset release does not fire.
  - Reset mid-transmission aborts immediately; tx_start never glitches high.
- Start edge detect:
  - start_q/tx_done_q are registered copies of start/tx_done.
  - An edge is cur=1 and prev=0.
  - Start edges arriving while busy=1 are ignored. A level still held high after done does not retrigger.
- FSM states: IDLE, LOAD, CONVERT, SEND, WAIT, FINISH.
- IDLE: waits for a start edge, then goes to LOAD with busy=1.
- LOAD (1 cycle):
  - Captures alu_in.
  - neg = SIGNED & alu_in[31]; mag = neg ? -alu_in : alu_in, as 32-bit unsigned. 0x80000000 gives 2147483648, which is correct.
  - If neg, pushes 8'h2D ('-') into the byte buffer.
  - Sets pow index k=9 (10^9).
- CONVERT:
  - One subtraction per cycle: if mag >= 10^k then mag -= 10^k and digit++.
  - Otherwise the digit is complete:
    - Push 8'h30+digit unless it is a leading zero.
    - A zero is leading only while nothing nonzero has been pushed and k>0.
    - Then k--.
  - After k=0 completes: if SEND_DELIM, push DELIM; then go to SEND.
  - Powers of ten come from a constant table.
  - Worst case ~100 cycles.
- Byte buffer: 12 entries ('-' + 10 digits + delimiter). A 4-bit count and a 4-bit read pointer.
- SEND (1 cycle): d_out = buf[rd]; tx_start = 1; go to WAIT.
- WAIT:
  - Waits for a tx_done edge. A tx_done already high at entry is not an edge and must fall first.
  - On the edge, rd++. If rd == count go to FINISH, else go to SEND.
- FINISH: done = 1 for one cycle, busy = 0, go to IDLE.
  - d_out keeps the last byte.
  - A start edge in the same cycle as done is ignored.
- Minimum output is 1 byte ("0" when SEND_DELIM=0); maximum is 12 bytes.
- tx_start is never high on two consecutive cycles and never high outside SEND.

Test Plan:
- alu_in=1234, SIGNED=1, start 0->1 (tx_done pulsed 20 cycles after each tx_start) -> bytes 0x31,0x32,0x33,0x34,0x20; exactly 5 tx_start pulses; done one cycle after the 5th tx_done edge; busy high throughout.
- alu_in=0 -> bytes 0x30,0x20. With SEND_DELIM=0 -> the single byte 0x30.
- alu_in=32'hFFFFFFFB:
  - SIGNED=1 -> 0x2D,0x35,0x20.
  - SIGNED=0 -> "4294967291 " (11 bytes).
- alu_in=32'h80000000, SIGNED=1 -> "-2147483648 " (12 bytes). The buffer maximum is reached without overflow.
- start held high across done, plus a second start edge during WAIT -> exactly one transmission, no extra tx_start. tx_done held high when entering WAIT does not advance the read pointer until it toggles.
- reset pulled low during the 3rd WAIT, then released with start=0 -> d_out, tx_start, busy and done all 0 immediately. A new start edge afterwards restarts from the first byte.
